sipo_tge: RTL and testbench
===========================

Name: sipo_tge

Overview:
- Receive-side counterpart of the 10GbE transmit serializer.
- Collects a stream of 64-bit words, each qualified by a valid strobe, into 512-bit words.
- Writes each completed 512-bit word into a downstream wide FIFO, using that FIFO's full/write-enable handshake.
- Sits between the 10GbE RX datapath and the wide buffering FIFO, so a 512-bit word passed through the serializer and then this block comes back bit-exact.

Parameters:
- INPUT_SIZE, 64: serial word width in bits.
- OUTPUT_SIZE, 512: parallel word width in bits; must be an integer multiple of INPUT_SIZE.
- CNT_W, 32: width of the written-word and dropped-word counters.
- Derived constant CYCLES_BTW = OUTPUT_SIZE/INPUT_SIZE = 8 lanes per parallel word.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high (already decided).
- ce  in  1  clock enable; when low, all state holds and fifo_we is 0.
- i_serial  in  INPUT_SIZE  incoming serial word.
- i_valid  in  1  i_serial is valid this cycle.
- i_last  in  1  end-of-frame marker; used only when the optional feature is compiled in.
- fifo_full  in  1  downstream FIFO cannot accept a write.
- fifo_we  out  1  write strobe to the FIFO.
- o_parallel  out  OUTPUT_SIZE  data to the FIFO; meaningful when fifo_we=1.
- overflow  out  1  sticky flag: a completed word was dropped.
- words_written  out  CNT_W  count of FIFO writes.
- words_dropped  out  CNT_W  count of dropped completed words.

Behaviour:
- Reset values: fifo_we=0, o_parallel=0, overflow=0, both counters=0, lane counter=0, pending=0, accumulator=0.
- Accept rule: a word is accepted when ce && i_valid (i_valid && ce is qualified).
- Lane placement: the k-th accepted word of a group (k=0..7) goes to accumulator bits [(k+1)*INPUT_SIZE-1 : k*INPUT_SIZE]. The first word lands in the LSBs.
- Lane counter: increments on each accepted word and wraps 7 -> 0 on the 8th.
- Completion: on the 8th accepted word (cycle N), the full word, including that 8th word, is copied into the o_parallel register and pending is set. The accumulator restarts at lane 0 with no dead cycle, so back-to-back valid is sustained indefinitely.
- Handshake: fifo_we = pending && !fifo_full && ce, combinational from registers.
  - A write clears pending at the clock edge and increments words_written.
  - Latency: 8th word accepted in cycle N -> fifo_we=1 in cycle N+1 if fifo_full=0.
- State machine on pending:
  - IDLE (pending=0) -> HELD on completion.
  - HELD -> IDLE on a write with no new completion.
  - HELD -> HELD either when a write and a new completion happen in the same cycle (the new word loads, no drop) or when fifo_full keeps it waiting.
- Overflow: a completion in HELD without a same-cycle write is handled as follows:
  - The new word is dropped and o_parallel keeps the older word.
  - overflow is set and words_dropped is incremented.
  - The lane counter still wraps, and accumulation continues.
- Backpressure: fifo_full never stalls input acceptance; there is no ready output.
- Counters saturate at all-ones and do not wrap.
- ce low: no accept, no write, counters hold, i_valid is ignored.
- Reset mid-operation: a partial accumulation is discarded and a pending word is discarded without being written. overflow and the counters clear. The first accepted word after reset goes to lane 0.

Optional Feature:
- Macro: SIPO_TGE_PAD_EN.
- Defined:
  - An accepted word with i_last=1 completes the group immediately.
  - Lanes above the current one are zero-filled, and the lane counter returns to 0.
  - The same pending/overflow rules apply.
  - i_last on the 8th lane behaves as a normal completion.
- Undefined: i_last is ignored, and only 8 accepted words complete a group.

Decomposition:
- Package sipo_tge_pkg holds:
  - CYCLES_BTW and the lane index width $clog2(CYCLES_BTW);
  - the pending-state encoding IDLE/HELD;
  - the default widths 64/512/32.
- No sub-module; the lane-indexed accumulator and the handshake stay in one module.

Test Plan:
- Streaming round trip: reset, then 8 consecutive valid words 0x0..0x7 with fifo_full=0.
  - Required: fifo_we=1 exactly one cycle after word 7.
  - Required: o_parallel[63:0]=0x0 and o_parallel[511:448]=0x7.
  - Required: words_written=1.
- Continuous stream: 64 valid words with fifo_full=0 -> 8 writes with no gaps in acceptance, words_written=8, overflow=0.
- Bubbles: valid asserted on every third cycle for 8 words -> a single write with the words packed in order; ce low for 5 cycles mid-group changes nothing.
- Backpressure:
  - Hold fifo_full=1 while 16 words arrive.
  - Required: the first group stays in o_parallel, the second is dropped, overflow=1, words_dropped=1.
  - Then release fifo_full: fifo_we pulses once with the first group.
- Simultaneous: fifo_full drops in the same cycle a second group completes -> the first group is written, the second loads, pending stays set, and it is written next cycle with no drop.
- Reset mid-group:
  - Send 5 words, assert rst for one cycle, then send 8 words 0x10..0x17.
  - Required: one write with o_parallel[63:0]=0x10.
  - With SIPO_TGE_PAD_EN: 3 words followed by i_last -> a write with lanes 3..7 equal to 0.

Source files
------------

// File: rtl/sipo_tge_pkg.sv
// Shared widths, lane geometry and pending-state encoding for the 10GbE
// receive-side serial-to-parallel collector.
package sipo_tge_pkg;

   localparam int INPUT_SIZE_DEF  = 64;
   localparam int OUTPUT_SIZE_DEF = 512;
   localparam int CNT_W_DEF       = 32;

   localparam int CYCLES_BTW = OUTPUT_SIZE_DEF / INPUT_SIZE_DEF;
   localparam int LANE_W     = $clog2(CYCLES_BTW);

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } pendState_t;

endpackage

// File: rtl/sipo_tge.sv
// Packs valid-qualified 64-bit words into 512-bit words and hands them to a
// wide FIFO. Optional macro SIPO_TGE_PAD_EN: i_last closes a group early, zero-filled.
module sipo_tge
   import sipo_tge_pkg::*;
#(
   parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
   parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic [INPUT_SIZE-1:0]  i_serial,
   input  logic                   i_valid,
   input  logic                   i_last,
   input  logic                   fifo_full,
   output logic                   fifo_we,
   output logic [OUTPUT_SIZE-1:0] o_parallel,
   output logic                   overflow,
   output logic [CNT_W-1:0]       words_written,
   output logic [CNT_W-1:0]       words_dropped
);

   localparam int LANES = OUTPUT_SIZE / INPUT_SIZE;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   pendState_t             r_state;
   logic [LW-1:0]          r_lane;
   logic [OUTPUT_SIZE-1:0] r_accum;
   logic [OUTPUT_SIZE-1:0] r_parallel;
   logic                   r_overflow;
   logic [CNT_W-1:0]       r_written;
   logic [CNT_W-1:0]       r_dropped;

   logic                   w_accept;
   logic                   w_lastHit;
   logic                   w_complete;
   logic                   w_write;
   logic [OUTPUT_SIZE-1:0] w_fullWord;

`ifdef SIPO_TGE_PAD_EN
   assign w_lastHit = i_last;
`else
   logic w_unusedLast;
   assign w_unusedLast = i_last;
   assign w_lastHit    = 1'b0;
`endif

   assign w_accept   = ce && i_valid;
   assign w_complete = w_accept && ((r_lane == LW'(LANES - 1)) || w_lastHit);
   // Reset gates the strobe so a discarded pending word never reaches the FIFO.
   assign w_write    = (r_state == HELD) && !fifo_full && ce && !rst;

   // Accumulator is cleared at each completion, so lanes above the current one
   // are already zero; this is what makes early-close padding free.
   always_comb begin
      w_fullWord = r_accum;
      for (int j = 0; j < LANES; j++) begin
         if (r_lane == LW'(j)) begin
            w_fullWord[j*INPUT_SIZE +: INPUT_SIZE] = i_serial;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_lane     <= '0;
         r_accum    <= '0;
         r_parallel <= '0;
         r_overflow <= 1'b0;
         r_written  <= '0;
         r_dropped  <= '0;
      end else if (ce) begin
         if (w_accept) begin
            if (w_complete) begin
               r_lane  <= '0;
               r_accum <= '0;
            end else begin
               r_lane  <= r_lane + LW'(1);
               r_accum <= w_fullWord;
            end
         end

         case (r_state)
            IDLE: begin
               if (w_complete) begin
                  r_parallel <= w_fullWord;
                  r_state    <= HELD;
               end
            end
            HELD: begin
               if (w_write) begin
                  if (r_written != '1) begin
                     r_written <= r_written + 1'b1;
                  end
                  if (w_complete) begin
                     r_parallel <= w_fullWord;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_complete) begin
                  // Older word wins; the newly completed one is lost.
                  r_overflow <= 1'b1;
                  if (r_dropped != '1) begin
                     r_dropped <= r_dropped + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fifo_we       = w_write;
   assign o_parallel    = r_parallel;
   assign overflow      = r_overflow;
   assign words_written = r_written;
   assign words_dropped = r_dropped;

endmodule

// File: tb/tb_sipo_tge.sv
// Self-checking bench for sipo_tge: random words against a queue-based model
// of the packing, hand-off, drop and reset rules.
module tb_sipo_tge;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ce = 1'b0;
   logic [63:0]  i_serial = '0;
   logic         i_valid = 1'b0;
   logic         i_last = 1'b0;
   logic         fifo_full = 1'b0;
   logic         fifo_we;
   logic [511:0] o_parallel;
   logic         overflow;
   logic [31:0]  words_written;
   logic [31:0]  words_dropped;

   int checks = 0;
   int bad = 0;

   logic [511:0] dWrites[$];
   logic [511:0] mWrites[$];
   logic [63:0]  mGroup[$];
   logic         mPending;
   logic [511:0] mHeld;
   logic [31:0]  mWritten;
   logic [31:0]  mDropped;
   logic         mOverflow;
   logic         obsWe;

`ifdef SIPO_TGE_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   sipo_tge dut (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .i_serial      (i_serial),
      .i_valid       (i_valid),
      .i_last        (i_last),
      .fifo_full     (fifo_full),
      .fifo_we       (fifo_we),
      .o_parallel    (o_parallel),
      .overflow      (overflow),
      .words_written (words_written),
      .words_dropped (words_dropped)
   );

   always #5 clk = ~clk;

   // Words of a group sit in arrival order, first word in the lowest 64 bits.
   function automatic logic [511:0] packGroup();
      logic [511:0] w;
      w = '0;
      for (int i = 0; i < mGroup.size(); i++) begin
         w[i*64 +: 64] = mGroup[i];
      end
      return w;
   endfunction

   // One clock of stimulus: drive at the falling edge, observe the DUT, then
   // advance the model to what the coming rising edge should produce.
   task automatic applyStimulus(input logic r, input logic c, input logic v,
                                input logic [63:0] d, input logic l, input logic f);
      logic willWrite;
      @(negedge clk);
      rst = r; ce = c; i_valid = v; i_serial = d; i_last = l; fifo_full = f;
      #1;
      obsWe = fifo_we;
      if (fifo_we === 1'b1) dWrites.push_back(o_parallel);
      willWrite = !r && c && mPending && !f;
      if (r) begin
         mGroup.delete();
         mPending = 1'b0; mHeld = '0; mWritten = '0; mDropped = '0; mOverflow = 1'b0;
      end else begin
         if (willWrite) begin
            mWrites.push_back(mHeld);
            mWritten++;
            mPending = 1'b0;
         end
         if (c && v) begin
            mGroup.push_back(d);
            if (mGroup.size() == 8 || (PAD_ON && l)) begin
               if (!mPending) begin
                  mHeld = packGroup();
                  mPending = 1'b1;
               end else begin
                  mOverflow = 1'b1;
                  mDropped++;
               end
               mGroup.delete();
            end
         end
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      dWrites.delete();
      mWrites.delete();
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 11; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b1);
      doReset();
      checks++; if (fifo_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got %b want 0", fifo_we); end
      checks++; if (o_parallel !== '0) begin bad++; $display("[TB] FAIL reset_parallel got %h want 0", o_parallel); end
      checks++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (words_written !== 32'd0) begin bad++; $display("[TB] FAIL reset_written got %0d want 0", words_written); end
      checks++; if (words_dropped !== 32'd0) begin bad++; $display("[TB] FAIL reset_dropped got %0d want 0", words_dropped); end
   endtask

   task automatic test_roundtrip();
      doReset();
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, 64'(k), 1'b0, 1'b0);
      checks++; if (obsWe !== 1'b0) begin bad++; $display("[TB] FAIL rt_early_we got %b want 0", obsWe); end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (obsWe !== 1'b1) begin bad++; $display("[TB] FAIL rt_we got %b want 1", obsWe); end
      checks++; if (dWrites.size() != 1) begin bad++; $display("[TB] FAIL rt_count got %0d want 1", dWrites.size()); end
      else begin
         checks++; if (dWrites[0][63:0] !== 64'h0) begin bad++; $display("[TB] FAIL rt_lane0 got %h want 0", dWrites[0][63:0]); end
         checks++; if (dWrites[0][511:448] !== 64'h7) begin bad++; $display("[TB] FAIL rt_lane7 got %h want 7", dWrites[0][511:448]); end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (words_written !== 32'd1) begin bad++; $display("[TB] FAIL rt_written got %0d want 1", words_written); end
   endtask

   task automatic test_continuous();
      doReset();
      for (int k = 0; k < 64; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 8) begin bad++; $display("[TB] FAIL cont_count got %0d want 8", dWrites.size()); end
      for (int i = 0; i < mWrites.size() && i < dWrites.size(); i++) begin
         checks++; if (dWrites[i] !== mWrites[i]) begin bad++; $display("[TB] FAIL cont_word%0d got %h want %h", i, dWrites[i], mWrites[i]); end
      end
      checks++; if (words_written !== 32'd8) begin bad++; $display("[TB] FAIL cont_written got %0d want 8", words_written); end
      checks++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL cont_overflow got %b want 0", overflow); end
   endtask

   task automatic test_bubbles();
      doReset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b0);
         if (k == 4) begin
            for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
         end else begin
            for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b1, 1'b0, rnd64(), 1'b0, 1'b0);
         end
      end
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 1) begin bad++; $display("[TB] FAIL bub_count got %0d want 1", dWrites.size()); end
      else begin
         checks++; if (dWrites[0] !== mWrites[0]) begin bad++; $display("[TB] FAIL bub_word got %h want %h", dWrites[0], mWrites[0]); end
      end
      checks++; if (words_written !== mWritten) begin bad++; $display("[TB] FAIL bub_written got %0d want %0d", words_written, mWritten); end
   endtask

   task automatic test_backpressure();
      int weSeen;
      doReset();
      weSeen = 0;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b1);
         if (obsWe === 1'b1) weSeen++;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      checks++; if (weSeen != 0) begin bad++; $display("[TB] FAIL bp_we_while_full got %0d want 0", weSeen); end
      checks++; if (o_parallel !== mHeld) begin bad++; $display("[TB] FAIL bp_held got %h want %h", o_parallel, mHeld); end
      checks++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL bp_overflow got %b want 1", overflow); end
      checks++; if (words_dropped !== 32'd1) begin bad++; $display("[TB] FAIL bp_dropped got %0d want 1", words_dropped); end
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 1) begin bad++; $display("[TB] FAIL bp_pulses got %0d want 1", dWrites.size()); end
      else begin
         checks++; if (dWrites[0] !== mWrites[0]) begin bad++; $display("[TB] FAIL bp_word got %h want %h", dWrites[0], mWrites[0]); end
      end
   endtask

   task automatic test_simultaneous();
      doReset();
      for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b0);
      checks++; if (obsWe !== 1'b1) begin bad++; $display("[TB] FAIL sim_first_we got %b want 1", obsWe); end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (obsWe !== 1'b1) begin bad++; $display("[TB] FAIL sim_second_we got %b want 1", obsWe); end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 2) begin bad++; $display("[TB] FAIL sim_count got %0d want 2", dWrites.size()); end
      for (int i = 0; i < mWrites.size() && i < dWrites.size(); i++) begin
         checks++; if (dWrites[i] !== mWrites[i]) begin bad++; $display("[TB] FAIL sim_word%0d got %h want %h", i, dWrites[i], mWrites[i]); end
      end
      checks++; if (words_dropped !== 32'd0) begin bad++; $display("[TB] FAIL sim_dropped got %0d want 0", words_dropped); end
      checks++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL sim_overflow got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid_group();
      doReset();
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, 64'(16 + k), 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 1) begin bad++; $display("[TB] FAIL rmid_count got %0d want 1", dWrites.size()); end
      else begin
         checks++; if (dWrites[0][63:0] !== 64'h10) begin bad++; $display("[TB] FAIL rmid_lane0 got %h want 10", dWrites[0][63:0]); end
         checks++; if (dWrites[0] !== mWrites[0]) begin bad++; $display("[TB] FAIL rmid_word got %h want %h", dWrites[0], mWrites[0]); end
      end
      checks++; if (words_written !== 32'd1) begin bad++; $display("[TB] FAIL rmid_written got %0d want 1", words_written); end
   endtask

`ifdef SIPO_TGE_PAD_EN
   task automatic test_pad();
      doReset();
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64() | 64'h1, (k == 2), 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, rnd64(), 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (dWrites.size() != 2) begin bad++; $display("[TB] FAIL pad_count got %0d want 2", dWrites.size()); end
      else begin
         checks++; if (dWrites[0][511:192] !== '0) begin bad++; $display("[TB] FAIL pad_zero got %h want 0", dWrites[0][511:192]); end
         for (int i = 0; i < 2; i++) begin
            checks++; if (dWrites[i] !== mWrites[i]) begin bad++; $display("[TB] FAIL pad_word%0d got %h want %h", i, dWrites[i], mWrites[i]); end
         end
      end
   endtask
`endif

   initial begin
      mPending = 1'b0; mHeld = '0; mWritten = '0; mDropped = '0; mOverflow = 1'b0; obsWe = 1'b0;
      $display("[TB] starting sipo_tge bench");
      test_reset();
      test_roundtrip();
      test_continuous();
      test_bubbles();
      test_backpressure();
      test_simultaneous();
      test_reset_mid_group();
`ifdef SIPO_TGE_PAD_EN
      test_pad();
`endif
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule
